fp_mul_ctrl: RTL

Sequencer and round-robin arbiter that shares one FP32 multiplier datapath (unpack, Booth product, normalize, round) among NREQ requesters. It accepts one operation at a time over valid/ready, holds operands stable on the core inputs for a fixed MUL_LAT cycles, then captures the result and flags. Zero and subnormal operands short-circuit to a signed zero without using the core. It sits between the issue logic and the multiplier core in the FPU.

---
 rtl/fp_mul_pkg.sv | 31 +++
 rtl/fp_mul_rr_arb.sv | 32 +++
 rtl/fp_mul_ctrl.sv | 158 +++++++++++++++
 3 files changed

// File: rtl/fp_mul_pkg.sv
// Shared types and FP32 field constants for the multiplier sequencer.
package fp_mul_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_e;

    localparam int unsigned FP_W     = 32;
    localparam int unsigned SIGN_BIT = 31;
    localparam int unsigned EXP_MSB  = 30;
    localparam int unsigned EXP_LSB  = 23;
    localparam logic [7:0]  EXP_MAX  = 8'hFF;

    localparam logic [2:0] RNE = 3'b000;
    localparam logic [2:0] RTZ = 3'b001;
    localparam logic [2:0] RDN = 3'b010;
    localparam logic [2:0] RUP = 3'b011;
    localparam logic [2:0] RMM = 3'b100;

    // Zero/subnormal times a finite or zero value flushes to a signed zero.
    function automatic logic is_bypass(input logic [FP_W-1:0] x, input logic [FP_W-1:0] y);
        logic [7:0] ex;
        logic [7:0] ey;
        ex = x[EXP_MSB:EXP_LSB];
        ey = y[EXP_MSB:EXP_LSB];
        return ((ex == 8'h00) && (ey != EXP_MAX)) || ((ey == 8'h00) && (ex != EXP_MAX));
    endfunction

endpackage

// File: rtl/fp_mul_rr_arb.sv
// Combinational round-robin arbiter; search starts one past the last grant.
module fp_mul_rr_arb #(
    parameter int unsigned NREQ = 2,
    parameter int unsigned ID_W = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [ID_W-1:0] last_grant,
    output logic [NREQ-1:0] grant_c,
    output logic [ID_W-1:0] grant_id_c,
    output logic            any_grant_c
);

    always_comb begin
        logic [ID_W-1:0] idx;
        logic            found;
        grant_c     = '0;
        grant_id_c  = '0;
        any_grant_c = 1'b0;
        idx         = '0;
        found       = 1'b0;
        for (int unsigned k = 1; k <= NREQ; k++) begin
            idx = ID_W'((32'(last_grant) + k) % NREQ);
            if (!found && req[idx]) begin
                found        = 1'b1;
                grant_c[idx] = 1'b1;
                grant_id_c   = idx;
            end
        end
        any_grant_c = found;
    end

endmodule

// File: rtl/fp_mul_ctrl.sv
// Sequencer sharing one external FP32 multiplier core among NREQ requesters.
module fp_mul_ctrl
    import fp_mul_pkg::*;
#(
    parameter int unsigned NREQ    = 2,
    parameter int unsigned MUL_LAT = 2
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NREQ-1:0]           req_valid,
    output logic [NREQ-1:0]           req_ready,
    input  logic [NREQ*32-1:0]        req_x,
    input  logic [NREQ*32-1:0]        req_y,
    input  logic [NREQ*3-1:0]         req_rmode,
    output logic                      rsp_valid,
    input  logic                      rsp_ready,
    output logic [31:0]               rsp_z,
    output logic                      rsp_ovrf,
    output logic                      rsp_udrf,
    output logic [$clog2(NREQ)-1:0]   rsp_id,
    output logic [31:0]               core_x,
    output logic [31:0]               core_y,
    output logic [2:0]                core_rmode,
    output logic                      core_start,
    input  logic [31:0]               core_z,
    input  logic                      core_ovrf,
    input  logic                      core_udrf
);

    localparam int unsigned ID_W  = $clog2(NREQ);
    localparam int unsigned CNT_W = $clog2(MUL_LAT + 1);

    state_e           state_q, state_d;
    logic [ID_W-1:0]  last_grant_q, last_grant_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [31:0]      x_d, y_d, rsp_z_d;
    logic [2:0]       rmode_d;
    logic             start_d, rsp_valid_d, rsp_ovrf_d, rsp_udrf_d;
    logic [ID_W-1:0]  rsp_id_d;

    logic [NREQ-1:0]  grant;
    logic [ID_W-1:0]  grant_id;
    logic             any_grant;
    logic [31:0]      sel_x, sel_y;
    logic [2:0]       sel_rmode;

    fp_mul_rr_arb #(.NREQ(NREQ), .ID_W(ID_W)) u_arb (
        .req         (req_valid),
        .last_grant  (last_grant_q),
        .grant_c     (grant),
        .grant_id_c  (grant_id),
        .any_grant_c (any_grant)
    );

    // Operand mux for the granted requester.
    always_comb begin
        sel_x     = '0;
        sel_y     = '0;
        sel_rmode = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (ID_W'(i) == grant_id) begin
                sel_x     = req_x[32*i +: 32];
                sel_y     = req_y[32*i +: 32];
                sel_rmode = req_rmode[3*i +: 3];
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        cnt_d        = cnt_q;
        x_d          = core_x;
        y_d          = core_y;
        rmode_d      = core_rmode;
        start_d      = 1'b0;
        rsp_valid_d  = rsp_valid;
        rsp_z_d      = rsp_z;
        rsp_ovrf_d   = rsp_ovrf;
        rsp_udrf_d   = rsp_udrf;
        rsp_id_d     = rsp_id;
        req_ready    = '0;
        unique case (state_q)
            IDLE: begin
                // Gated by rst_n so nothing is offered while reset is held.
                if (rst_n) begin
                    req_ready = grant;
                end
                if (any_grant) begin
                    last_grant_d = grant_id;
                    x_d          = sel_x;
                    y_d          = sel_y;
                    rmode_d      = sel_rmode;
                    rsp_id_d     = grant_id;
                    if (is_bypass(sel_x, sel_y)) begin
                        rsp_z_d     = {sel_x[SIGN_BIT] ^ sel_y[SIGN_BIT], 31'b0};
                        rsp_ovrf_d  = 1'b0;
                        rsp_udrf_d  = 1'b0;
                        rsp_valid_d = 1'b1;
                        state_d     = RESP;
                    end else begin
                        cnt_d   = CNT_W'(MUL_LAT);
                        start_d = 1'b1;
                        state_d = BUSY;
                    end
                end
            end
            BUSY: begin
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    rsp_z_d     = core_z;
                    rsp_ovrf_d  = core_ovrf;
                    rsp_udrf_d  = core_udrf;
                    rsp_valid_d = 1'b1;
                    state_d     = RESP;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            last_grant_q <= ID_W'(NREQ - 1);
            cnt_q        <= '0;
            core_x       <= '0;
            core_y       <= '0;
            core_rmode   <= '0;
            core_start   <= 1'b0;
            rsp_valid    <= 1'b0;
            rsp_z        <= '0;
            rsp_ovrf     <= 1'b0;
            rsp_udrf     <= 1'b0;
            rsp_id       <= '0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            cnt_q        <= cnt_d;
            core_x       <= x_d;
            core_y       <= y_d;
            core_rmode   <= rmode_d;
            core_start   <= start_d;
            rsp_valid    <= rsp_valid_d;
            rsp_z        <= rsp_z_d;
            rsp_ovrf     <= rsp_ovrf_d;
            rsp_udrf     <= rsp_udrf_d;
            rsp_id       <= rsp_id_d;
        end
    end

endmodule
